// File: rtl/fifo_burst_rd_m.sv
// Burst drain stage for a single-clock FWFT FIFO: pops the FIFO head as bursts of up to
// BURST_LEN beats on a valid/ready stream, flushing a partial burst after TIMEOUT idle cycles.
module fifo_burst_rd_m #(
  parameter type DATA_ITEM_TYPE = logic,
  parameter int  DEPTH          = 32,
  parameter int  BURST_LEN      = 8,
  parameter int  TIMEOUT        = 64,
  localparam int DATA_COUNT_W   = $clog2(DEPTH + 1),
  localparam int LEN_W          = $clog2(BURST_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  DATA_ITEM_TYPE           head,
  input  logic                    empty,
  input  logic [DATA_COUNT_W-1:0] data_count,
  input  logic                    rd_rst_busy,
  output logic                    pop,
  output DATA_ITEM_TYPE           m_data,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    busy,
  output logic [LEN_W-1:0]        burst_len
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]   burst_len_q, burst_len_d;

  logic full_ok;
  logic tmo_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
    end
  end

  // Full bursts win over the timeout flush when both are possible.
  assign full_ok = (data_count >= DATA_COUNT_W'(BURST_LEN));
  assign tmo_ok  = (wait_cnt_q == WAIT_W'(TIMEOUT)) && (data_count != '0);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    case (state_q)
      S_IDLE: begin
        if (empty) begin
          wait_cnt_d = '0;
        end else if (!rd_rst_busy && (wait_cnt_q != WAIT_W'(TIMEOUT))) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (!rd_rst_busy && (full_ok || tmo_ok)) begin
          state_d    = S_BURST;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
          // Timeout path only: data_count is below BURST_LEN here, so truncation is safe.
          burst_len_d = full_ok ? LEN_W'(BURST_LEN) : LEN_W'(data_count);
        end
      end
      S_BURST: begin
        wait_cnt_d = '0;
        if (pop) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          if (m_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_BURST);
    burst_len = burst_len_q;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    pop       = 1'b0;
    m_data    = '0;
    if (state_q == S_BURST) begin
      m_valid = !empty && !rd_rst_busy;
      m_data  = head;
      m_last  = m_valid && (beat_cnt_q == (burst_len_q - LEN_W'(1)));
      pop     = m_valid && m_ready;
    end
  end

endmodule

// File: tb/tb_fifo_burst_rd_m.sv
// Bench for fifo_burst_rd_m: a queue-based FWFT FIFO feeds the DUT, and a negedge monitor
// scores every beat against the pushed items and the expected burst framing.
module tb_fifo_burst_rd_m;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int BL    = 8;
  localparam int TO    = 64;
  localparam int DCW   = $clog2(DEPTH + 1);
  localparam int LW    = $clog2(BL + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  head;
  logic           empty;
  logic [DCW-1:0] data_count;
  logic           rd_rst_busy;
  logic           pop;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_last;
  logic           m_ready;
  logic           busy;
  logic [LW-1:0]  burst_len;

  fifo_burst_rd_m #(
    .DATA_ITEM_TYPE(logic [DW-1:0]),
    .DEPTH         (DEPTH),
    .BURST_LEN     (BL),
    .TIMEOUT       (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .head       (head),
    .empty      (empty),
    .data_count (data_count),
    .rd_rst_busy(rd_rst_busy),
    .pop        (pop),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .burst_len  (burst_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 3;   // 0: ready high, 1: toggle, 2: random, other: ready low
  int hs_total = 0;

  logic [DW-1:0] fifo_q[$];   // FIFO contents as the DUT sees them
  logic [DW-1:0] exp_q[$];    // items still owed on the stream, in order

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    empty      = (fifo_q.size() == 0);
    data_count = DCW'(fifo_q.size());
    head       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_batch(input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = DW'($urandom);
      fifo_q.push_back(v);
      exp_q.push_back(v);
    end
    drive_fifo();
  endtask

  task automatic tick();
    logic          do_pop;
    logic [DW-1:0] dummy;
    @(negedge clk);
    do_pop = pop;
    @(posedge clk);
    if (do_pop && fifo_q.size() != 0) dummy = fifo_q.pop_front();
    #1;
    case (mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    drive_fifo();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", (fifo_q.size() == 0) && !busy, 1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_total < target && n < budget) begin
      tick();
      n++;
    end
    check("handshakes_reached", hs_total >= target, 1);
  endtask

  // Monitor / scoreboard
  initial begin
    int            beat_idx = 0;
    int            exp_len = 0;
    int            ready_cyc = 0;
    int            d;
    bit            started = 0;
    bit            prev_stall = 0;
    bit            cond, cond_prev = 0;
    logic [DW-1:0] stall_data = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        beat_idx = 0; started = 0; prev_stall = 0; cond_prev = 0;
      end else begin
        check("valid_rule", m_valid, busy && !empty && !rd_rst_busy);
        check("pop_rule", pop, m_valid && m_ready);
        if (prev_stall && !rd_rst_busy) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, stall_data);
        end
        if (m_valid && !started) begin
          started = 1;
          exp_len = (fifo_q.size() >= BL) ? BL : fifo_q.size();
          d = cyc - ready_cyc;
          if (exp_len == BL) check("full_start_latency", d, 1);
          else               check("timeout_window", (d >= TO) && (d <= TO + 3), 1);
        end
        if (m_valid) begin
          check("burst_len", burst_len, exp_len);
          check("m_last", m_last, beat_idx == exp_len - 1);
        end
        if (m_valid && m_ready) begin
          hs_total++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("data", m_data, e);
          end
          if (beat_idx == exp_len - 1) begin
            beat_idx = 0;
            started  = 0;
          end else begin
            beat_idx++;
          end
        end
        prev_stall = m_valid && !m_ready;
        stall_data = m_data;
        cond = !empty && !rd_rst_busy && !busy;
        if (cond && !cond_prev) ready_cyc = cyc;
        cond_prev = cond;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; m_ready = 1'b0; rd_rst_busy = 1'b0; mode = 3;
    drive_fifo();
    repeat (3) tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_pop", pop, 0);
    check("rst_busy", busy, 0);
    check("rst_burst_len", burst_len, 0);
    check("rst_m_last", m_last, 0);
    rst = 1'b0;
    mode = 0;
    tick();

    // Full burst
    push_batch(8);
    drain(200);
    check("full_burst_len_held", burst_len, 8);

    // Timeout flush
    push_batch(3);
    drain(200);
    check("timeout_burst_len_held", burst_len, 3);

    // Backpressure
    mode = 1;
    push_batch(8);
    drain(200);

    // Back-to-back
    mode = 0;
    push_batch(20);
    drain(400);
    check("b2b_burst_len_held", burst_len, 4);

    // Reset mid-burst
    push_batch(8);
    base = hs_total;
    wait_hs(base + 3, 50);
    mode = 3; m_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_pop", pop, 0);
    check("midrst_busy", busy, 0);
    check("midrst_burst_len", burst_len, 0);
    mode = 0;
    drain(300);
    check("midrst_flush_len", burst_len, 5);

    // rd_rst_busy held in IDLE
    rd_rst_busy = 1'b1;
    push_batch(6);
    repeat (100) tick();
    check("rrb_idle_busy", busy, 0);
    check("rrb_idle_fifo_kept", fifo_q.size(), 6);
    rd_rst_busy = 1'b0;
    drain(300);
    check("rrb_flush_len", burst_len, 6);

    // rd_rst_busy mid-burst
    push_batch(8);
    base = hs_total;
    wait_hs(base + 3, 50);
    rd_rst_busy = 1'b1;
    repeat (5) tick();
    check("rrb_mid_busy", busy, 1);
    check("rrb_mid_valid", m_valid, 0);
    check("rrb_mid_fifo_kept", fifo_q.size(), 5);
    rd_rst_busy = 1'b0;
    drain(200);

    // Random rounds
    mode = 2;
    for (int r = 0; r < 8; r++) begin
      push_batch($urandom_range(1, 24));
      drain(600);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
